// File: rtl/ifid_hazard_ctrl.sv
// IF/ID hazard sequencer: load-use stall, branch flush, memory-wait freeze.
// Optional perf counters built when IFID_HAZARD_PERF_CNT_EN is defined.
module ifid_hazard_ctrl #(
  parameter int REG_W        = 5,
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 255,
  parameter int CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs2,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             branch_taken,
  input  logic             mem_busy,
  output logic             pc_write_en,
  output logic             ifid_write_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             freeze,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {RUN, FLUSH, MEM_WAIT} state_t;

  localparam int TO_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(MEM_TIMEOUT);
  localparam logic [3:0] FL_LOAD = 4'(FLUSH_CYCLES - 1);
  localparam bit FL_MULTI = (FLUSH_CYCLES > 1);

  state_t state_q, state_d, resume_q, resume_d, eff;
  logic [3:0] fcnt_q, fcnt_d;
  logic [TO_W-1:0] busy_q, busy_d;
  logic timeout_q;
  logic load_use;

  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((ex_rd == id_rs1) ||
                     (id_uses_rs2 && (ex_rd == id_rs2)));

  // Once memory is ready the wait state behaves as the state it resumes.
  assign eff = (state_q == MEM_WAIT && !mem_busy) ? resume_q : state_q;

  always_comb begin
    state_d       = state_q;
    resume_d      = resume_q;
    fcnt_d        = fcnt_q;
    pc_write_en   = 1'b1;
    ifid_write_en = 1'b1;
    ifid_flush    = 1'b0;
    idex_bubble   = 1'b0;
    freeze        = 1'b0;
    if (reset) begin
      state_d  = RUN;
      resume_d = RUN;
      fcnt_d   = '0;
    end else if (mem_busy) begin
      freeze        = 1'b1;
      pc_write_en   = 1'b0;
      ifid_write_en = 1'b0;
      state_d       = MEM_WAIT;
      if (state_q != MEM_WAIT)
        resume_d = (state_q == FLUSH) ? FLUSH : RUN;
    end else begin
      state_d = eff;
      unique case (eff)
        RUN: begin
          if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            fcnt_d      = FL_LOAD;
            state_d     = FL_MULTI ? FLUSH : RUN;
          end else if (load_use) begin
            pc_write_en   = 1'b0;
            ifid_write_en = 1'b0;
            idex_bubble   = 1'b1;
          end
        end
        FLUSH: begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          if (branch_taken) begin
            fcnt_d  = FL_LOAD;
            state_d = FL_MULTI ? FLUSH : RUN;
          end else begin
            fcnt_d  = 4'(fcnt_q - 4'd1);
            state_d = (fcnt_q <= 4'd1) ? RUN : FLUSH;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    busy_d = '0;
    if (mem_busy)
      busy_d = (busy_q == TO_MAX) ? busy_q : TO_W'(busy_q + 1'b1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= RUN;
      resume_q  <= RUN;
      fcnt_q    <= '0;
      busy_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      resume_q <= resume_d;
      fcnt_q   <= fcnt_d;
      busy_q   <= busy_d;
      if (mem_busy && busy_d == TO_MAX)
        timeout_q <= 1'b1;
    end
  end

  assign mem_timeout = timeout_q;

`ifdef IFID_HAZARD_PERF_CNT_EN
  logic stall_ev, flush_ev;
  logic [CNT_W-1:0] stall_q, flush_q;

  assign stall_ev = !reset && !mem_busy && eff == RUN &&
                    !branch_taken && load_use;
  assign flush_ev = !reset && !mem_busy && branch_taken;

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_ev && stall_q != '1)
        stall_q <= stall_q + 1'b1;
      if (flush_ev && flush_q != '1)
        flush_q <= flush_q + 1'b1;
    end
  end

  assign stall_count = stall_q;
  assign flush_count = flush_q;
`else
  assign stall_count = '0;
  assign flush_count = '0;
`endif

endmodule
